// File: rtl/divider_arb_pkg.sv
// Shared types and constants for divider_arbiter and its round-robin picker.
package divider_arb_pkg;

  localparam int DOUBLE_W = 64;
  localparam logic [DOUBLE_W-1:0] DOUBLE_QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority select: first asserted request at or after ptr_i, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int cand;

  // NOTE: every variable gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    // Walk from the farthest offset down so the nearest request wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[IDX_W'(cand)]) begin
        idx_o = IDX_W'(cand);
        any_o = 1'b1;
      end
    end
  end

  assign grant_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one double_divider among NUM_REQ requesters.
// Optional watchdog in WAIT: define DIVIDER_ARB_TIMEOUT_EN.
module divider_arbiter
  import divider_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DOUBLE_W-1:0]  req_a,
  input  logic [NUM_REQ*DOUBLE_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DOUBLE_W-1:0]          rsp_data,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [DOUBLE_W-1:0]          div_a,
  output logic [DOUBLE_W-1:0]          div_b,
  output logic                         div_start,
  input  logic [DOUBLE_W-1:0]          div_out,
  input  logic                         div_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("divider_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [DOUBLE_W-1:0]  div_a_q, div_a_d;
  logic [DOUBLE_W-1:0]  div_b_q, div_b_d;
  logic [DOUBLE_W-1:0]  rsp_data_q, rsp_data_d;
  logic                 done_q;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [DOUBLE_W-1:0]  req_a_arr [NUM_REQ];
  logic [DOUBLE_W-1:0]  req_b_arr [NUM_REQ];

`ifdef DIVIDER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a_arr[i] = req_a[i*DOUBLE_W +: DOUBLE_W];
      req_b_arr[i] = req_b[i*DOUBLE_W +: DOUBLE_W];
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    rsp_data_d = rsp_data_q;
`ifdef DIVIDER_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          div_a_d = req_a_arr[pick_idx];
          div_b_d = req_b_arr[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef DIVIDER_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // Only a fresh rising edge completes; a level left over from the last op does not.
        if (div_done && !done_q) begin
          rsp_data_d = div_out;
          state_d    = RESPOND;
`ifdef DIVIDER_ARB_TIMEOUT_EN
          err_d      = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = DOUBLE_QNAN;
          err_d      = 1'b1;
          state_d    = RESPOND;
        end else begin
          cnt_d      = cnt_q + 1'b1;
`endif
        end
      end
      RESPOND: begin
        rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      rsp_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      rsp_data_q <= rsp_data_d;
      done_q     <= div_done;
    end
  end

`ifdef DIVIDER_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = (state_q == RESPOND) && err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Gated by rst so a requester held valid through reset never sees a stray accept.
  assign req_ready = (state_q == IDLE && !rst) ? pick_grant : '0;
  assign rsp_valid = (state_q == RESPOND) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign busy      = (state_q != IDLE);
  assign div_start = (state_q == ISSUE);
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter: vector table, continuous round-robin, level done, reset, random traffic.
module tb_divider_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, rsp_valid;
  logic [N*64-1:0]   req_a, req_b;
  logic [63:0]       rsp_data, div_a, div_b, div_out;
  logic              rsp_err, busy, div_start, div_done;

  int checks = 0, failures = 0;
  int start_cnt = 0, rsp_cnt = 0;
  int mptr = 0;

  // Divider stand-in controls
  int  m_lat = 1, m_cnt = 0;
  bit  m_hold = 0, m_never = 0, m_pend = 0;
  logic [63:0] m_q = '0;

  typedef struct {
    int          idx;
    logic [63:0] a, b, q;
    int          lat;
    bit          hold;
    int          exp_lat;
  } vec_t;
  localparam int NV = 6;
  vec_t vec [NV];

  divider_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_out(div_out), .div_done(div_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] div_model(input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < NV; i++)
      if (vec[i].a == a && vec[i].b == b) return vec[i].q;
    return $realtobits($bitstoreal(a) / $bitstoreal(b));
  endfunction

  // Divider model: latency after start, optional level-held done, optional never-done.
  initial begin
    div_done = 1'b0;
    div_out  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pend = 0; div_done = 1'b0;
      end else if (div_start) begin
        m_pend = 1; m_cnt = m_lat; m_q = div_model(div_a, div_b);
        if (!m_hold) div_done = 1'b0;
      end else if (m_pend && !m_never) begin
        if (m_cnt > 0) m_cnt--;
        else if (div_done) div_done = 1'b0;
        else begin div_done = 1'b1; div_out = m_q; m_pend = 0; end
      end else if (!m_hold) begin
        div_done = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (div_start) start_cnt++;
    if (rsp_valid != '0) rsp_cnt++;
  end

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
    req_valid[i] = 1'b1;
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
  endtask

  // One operation from accept to response; call at a negedge with requests already driven.
  task automatic serve(input int g, input logic [63:0] a, input logic [63:0] b, input logic [63:0] q,
                       input bit err, input int lat_exp, input bit drop);
    bit got;
    int n, s0;
    got = 0;
    for (int t = 0; t < 64 && !got; t++) begin
      #1;
      if (req_ready != '0) got = 1;
      else @(negedge clk);
    end
    check("accept_seen", 64'(got), 64'd1);
    if (!got) return;
    check("req_ready", 64'(req_ready), 64'(1 << g));
    s0 = start_cnt; n = 0; got = 0;
    while (n < 3000 && !got) begin
      @(negedge clk); n++;
      if (n == 1) begin
        check("div_start", 64'(div_start), 64'd1);
        check("div_a", div_a, a);
        check("div_b", div_b, b);
        if (drop) req_valid[g] = 1'b0;
      end
      if (rsp_valid != '0) got = 1;
    end
    check("rsp_seen", 64'(got), 64'd1);
    check("rsp_valid", 64'(rsp_valid), 64'(1 << g));
    check("rsp_data", rsp_data, q);
    check("rsp_err", 64'(rsp_err), 64'(err));
    check("latency", 64'(n), 64'(lat_exp));
    check("starts_per_op", 64'(start_cnt - s0), 64'd1);
    mptr = (g + 1) % N;
    @(negedge clk);
    check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    check("idle_after_rsp", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_div_start"}, 64'(div_start), 64'd0);
    check({tag, "_div_a"},     div_a,          64'd0);
    check({tag, "_div_b"},     div_b,          64'd0);
    check({tag, "_rsp_data"},  rsp_data,       64'd0);
  endtask

  initial begin
    int g, lat, r0;
    bit got;
    logic [63:0] ea, eb;

    vec[0] = '{2, 64'h3FF3AE147AE147AE, 64'h40123D70A3D70A3D, 64'h3FD1435E50D79436, 2, 0, 5};
    vec[1] = '{0, 64'h40E7FF26B851EB85, 64'hC0DBBC53851EB852, 64'hBFFBAFA8D7379D3D, 1, 1, 4};
    vec[2] = '{1, 64'h4000000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 2, 1, 6};
    vec[3] = '{3, 64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 0, 0, 3};
    vec[4] = '{0, 64'h7FF8000000000000, 64'h0000000000000000, 64'hFFF8000000000001, 4, 0, 7};
    vec[5] = '{0, 64'h409ED5ECFBFC6541, 64'h40C201336E2EB1C4, 64'h3FCB66FEA2BB1FB6, 1, 0, 4};

    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    mptr = 0;

    // All requesters valid continuously: grants 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, vec[5].a, vec[5].b);
    m_lat = vec[5].lat; m_hold = 0;
    for (int k = 0; k < N + 1; k++)
      serve(k % N, vec[5].a, vec[5].b, vec[5].q, 0, vec[5].exp_lat, 0);
    req_valid = '0;

    // Table vectors, including level-held done across consecutive operations
    for (int v = 0; v < 5; v++) begin
      req_valid = '0;
      set_req(vec[v].idx, vec[v].a, vec[v].b);
      m_lat = vec[v].lat; m_hold = vec[v].hold;
      serve(vec[v].idx, vec[v].a, vec[v].b, vec[v].q, 0, vec[v].exp_lat, 1);
    end
    m_hold = 0;
    req_valid = '0;

    // Randomized traffic against round-robin reference
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(1, 0) == 1) set_req(i, {$urandom, $urandom}, {$urandom, $urandom});
      if (req_valid == '0) set_req(it % N, {$urandom, $urandom}, {$urandom, $urandom});
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      lat = $urandom_range(4, 0);
      m_lat = lat;
      ea = req_a[g*64 +: 64]; eb = req_b[g*64 +: 64];
      serve(g, ea, eb, div_model(ea, eb), 0, 3 + lat, 1);
    end
    req_valid = '0;

    // Reset in WAIT: op dropped, rr_ptr back to 0
    m_lat = 1;
    set_req(1, vec[0].a, vec[0].b);
    serve(1, vec[0].a, vec[0].b, vec[0].q, 0, 4, 1);
    set_req(3, vec[3].a, vec[3].b);
    m_lat = 50;
    #1;
    check("rst_pre_grant", 64'(req_ready), 64'(1 << 3));
    repeat (3) @(negedge clk);
    check("rst_pre_busy", 64'(busy), 64'd1);
    set_req(1, vec[0].a, vec[0].b);
    r0 = rsp_cnt;
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    m_lat = 1;
    serve(1, vec[0].a, vec[0].b, vec[0].q, 0, 4, 1);
    check("rst_no_stale_rsp", 64'(rsp_cnt - r0), 64'd1);
    req_valid = '0;

`ifdef DIVIDER_ARB_TIMEOUT_EN
    m_never = 1;
    set_req(2, vec[0].a, vec[0].b);
    serve(2, vec[0].a, vec[0].b, QNAN, 1, 2 + TO, 1);
    m_never = 0;
`else
    // Without the watchdog, WAIT holds until the divider finally completes.
    m_never = 1; m_lat = 0;
    set_req(2, vec[3].a, vec[3].b);
    #1;
    check("nowdog_grant", 64'(req_ready), 64'(1 << 2));
    @(negedge clk);
    req_valid = '0;
    r0 = rsp_cnt;
    repeat (TO + 24) @(negedge clk);
    check("nowdog_busy", 64'(busy), 64'd1);
    check("nowdog_no_rsp", 64'(rsp_cnt - r0), 64'd0);
    m_never = 0;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid != '0) got = 1;
    end
    check("nowdog_rsp", 64'(rsp_valid), 64'(1 << 2));
    check("nowdog_data", rsp_data, vec[3].q);
    check("nowdog_err", 64'(rsp_err), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Round-robin controller that shares one `double_divider` instance among `NUM_REQ` requesters. It accepts one IEEE-754 double division request at a time and sequences the divider's single-cycle start pulse and done indication. It returns the 64-bit quotient to the requester that issued it. It sits between the compute clients and the `double_divider`/Dawson pair, on the same clock and reset as the divider.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in WAIT. Used only with `DIVIDER_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester request.
- `req_a` in `NUM_REQ`×64: dividend, packed, requester i at bits [64i+63:64i].
- `req_b` in `NUM_REQ`×64: divisor, same packing.
- `req_ready` out `NUM_REQ`: one-hot accept.
- `rsp_valid` out `NUM_REQ`: one-hot, one-cycle response pulse.
- `rsp_data` out 64: quotient, shared by all requesters.
- `rsp_err` out 1: timeout flag, qualified by `rsp_valid`.
- `busy` out 1: high in any state other than IDLE.
- `div_a` out 64: dividend to divider `a`.
- `div_b` out 64: divisor to divider `b`.
- `div_start` out 1: one-cycle pulse to divider `ready_in`.
- `div_out` in 64: divider `out`.
- `div_done` in 1: divider `ready_out`, which may be a level.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE:**
  - If any `req_valid` is high, grant `g`. `g` is the first valid index at or after `rr_ptr`, searching upward with wrap.
  - `req_ready[g]` is combinationally high in that cycle only.
  - At the clock edge, register `req_a[g]` and `req_b[g]` into `div_a` and `div_b`, store `g`, and go to ISSUE.
- **ISSUE:**
  - `div_start`=1 for exactly this one cycle.
  - Go to WAIT.
- **WAIT:**
  - `div_done` is registered every cycle into `done_q`.
  - Completion is a rising edge: `div_done && !done_q`. A level left high from the previous operation must not complete a new one.
  - On completion, register `div_out` into `rsp_data` and go to RESPOND.
- **RESPOND:**
  - `rsp_valid[g]`=1 for one cycle.
  - `rr_ptr` ← (g+1) mod `NUM_REQ`.
  - Go to IDLE.
- `div_a`, `div_b` and `rsp_data` hold their values until the next capture.
- Requests other than the granted one are ignored while `busy`. A requester may drop `req_valid` before it is accepted without any effect.
- The block does no arithmetic. Quotients, signs, NaN and Inf are passed through from the divider unchanged.

## Timing
- Reset (async assert, sync release):
  - State is IDLE and `rr_ptr`=0.
  - `req_ready`, `rsp_valid`, `rsp_err`, `busy` and `div_start` are 0.
  - `div_a`, `div_b` and `rsp_data` are 64'h0.
  - `done_q`=0 and the timeout counter is 0.
- Latency: accept in cycle C0, `div_start` in C1, WAIT from C2.
  - A `div_done` rising edge in cycle Cd gives `rsp_valid` in Cd+1.
  - The earliest next accept is Cd+2.
- `div_done` seen during IDLE, ISSUE or RESPOND only updates `done_q`; it never completes an operation.
- Simultaneous requests: only one grant per IDLE visit.
  - With all requesters valid continuously, grants go 0,1,2,3,0,…
  - Starvation is bounded by `NUM_REQ` operations.
- A requester whose `rsp_valid` pulses while its `req_valid` is still high is re-granted only when its round-robin turn comes.
- Reset mid-operation: the in-flight request is dropped and no `rsp_valid` is produced. The requester must re-present after reset.

## Configuration
- `DIVIDER_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT and clears on entry.
  - When it reaches `TIMEOUT_CYCLES` with no completion, go to RESPOND with `rsp_err`=1 and `rsp_data`=64'h7FF8000000000000 (qNaN).
  - `rr_ptr` advances normally.
- `DIVIDER_ARB_TIMEOUT_EN` undefined:
  - No counter exists and `rsp_err` is tied to 0.
  - WAIT lasts indefinitely.

## Structure
- Package `divider_arb_pkg` contains:
  - state enum `arb_state_t` (IDLE, ISSUE, WAIT, RESPOND);
  - `DOUBLE_QNAN` = 64'h7FF8000000000000;
  - `DOUBLE_W` = 64.
- Sub-module `rr_pick`: combinational rotate-priority select. Inputs are the `NUM_REQ` request vector and `rr_ptr`; outputs are the one-hot grant, the index, and `any`.

## Test plan
- Single request: requester 2, a=64'h3FF3AE147AE147AE, b=64'h40123D70A3D70A3D -> one `rsp_valid[2]` pulse, `rsp_data`=64'h3FD1435E50D79436, `rsp_err`=0.
- All four requesters valid from reset, requester i with a=64'h409ED5ECFBFC6541, b=64'h40C201336E2EB1C4 -> responses in order 0,1,2,3, each 64'h3FCB66FEA2BB1FB6, exactly one `div_start` per operation.
- Negative operand: a=64'h40E7FF26B851EB85, b=64'hC0DBBC53851EB852 -> `rsp_data`=64'hBFFBAFA8D7379D3D. Divider model holds `div_done` high through the next accept -> second operation waits for a fresh rising edge.
- `rst` asserted in WAIT -> all outputs 0 within the same cycle, no `rsp_valid`. After release, requester 1 is re-served correctly with `rr_ptr`=0.
- With the macro defined, `TIMEOUT_CYCLES`=16 and the divider model never asserting `div_done` -> `rsp_valid` 16 cycles after WAIT entry, with `rsp_err`=1 and `rsp_data`=64'h7FF8000000000000.
